// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: next-PC select codes, sequencer states,
// reset PC and the NOP word used for IF/ID bubbles.
package pipe_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JR  = 2'b10;
    localparam logic [1:0] NPC_J   = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bundle: ID requests, next-PC mux return, imem data in;
// select code, PC values, IF/ID contents, halt/count status out.
// Optional align_err member present when PC_ALIGN_CHK_EN is defined.
interface pc_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             br_taken_d;
    logic             jr_d;
    logic             j_d;
    logic             halt_req_d;
    logic [31:0]      npc;
    logic [31:0]      instr_f;
    logic [1:0]       npc_sel;
    logic [31:0]      pc_f;
    logic [31:0]      pc4_f;
    logic [31:0]      instr_d;
    logic [31:0]      pc_d;
    logic [31:0]      pc8_d;
    logic             valid_d;
    logic             halted;
    logic [CNT_W-1:0] fetch_cnt;
`ifdef PC_ALIGN_CHK_EN
    logic             align_err;
`endif

    modport master (
        output stall, br_taken_d, jr_d, j_d, halt_req_d,
        output npc, instr_f,
        input  npc_sel, pc_f, pc4_f, instr_d, pc_d, pc8_d,
        input  valid_d, halted, fetch_cnt
`ifdef PC_ALIGN_CHK_EN
        , input align_err
`endif
    );

    modport slave (
        input  stall, br_taken_d, jr_d, j_d, halt_req_d,
        input  npc, instr_f,
        output npc_sel, pc_f, pc4_f, instr_d, pc_d, pc8_d,
        output valid_d, halted, fetch_cnt
`ifdef PC_ALIGN_CHK_EN
        , output align_err
`endif
    );

endinterface

// File: rtl/pc_sequencer_if_id_reg.sv
// IF/ID pipeline register. Ports: clk, rst_n, i_hold (keep contents),
// i_bubble (load NOP, valid=0; wins over hold), i_instr/i_pc in, o_* out.
module if_id_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hold,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_valid;

    // A bubble keeps the old PC; only the instruction and valid flag clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP_WORD;
            r_pc    <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage sequencer: PC register, IF/ID register, next-PC select,
// stall/redirect/halt control and fetch counter.
// Ports: clk, reset_n (async active-low), bus (pc_sequencer_if.slave).
// Optional PC_ALIGN_CHK_EN: misaligned npc halts and sets sticky align_err.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
    parameter int          CNT_W    = 32
) (
    input logic           clk,
    input logic           reset_n,
    pc_sequencer_if.slave bus
);
    import pipe_pkg::*;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_halted;
`ifdef PC_ALIGN_CHK_EN
    logic             r_align_err;
    logic             w_align_trip;
`endif

    logic [31:0] w_pc4;
    logic [31:0] w_instr_d;
    logic [31:0] w_pc_d;
    logic        w_valid_d;
    logic        w_hold;
    logic        w_bubble;
    logic        w_adv;
    logic        w_stop;
    logic        w_halt_hit;
    logic        w_misalign;
    logic [1:0]  w_sel;

    assign w_pc4      = r_pc + 32'd4;
    assign w_halt_hit = bus.halt_req_d && w_valid_d;

`ifdef PC_ALIGN_CHK_EN
    assign w_misalign   = (bus.npc[1:0] != 2'b00);
    assign w_align_trip = (r_state == ST_RUN) && !w_halt_hit
                          && !bus.stall && w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    // Select code only means something for a live instruction in RUN.
    always_comb begin
        w_sel = NPC_PC4;
        if ((r_state == ST_RUN) && w_valid_d) begin
            if (bus.j_d) begin
                w_sel = NPC_J;
            end else if (bus.jr_d) begin
                w_sel = NPC_JR;
            end else if (bus.br_taken_d) begin
                w_sel = NPC_BR;
            end
        end
    end

    // Halt beats stall; stall beats advance.
    always_comb begin
        w_hold   = 1'b1;
        w_bubble = 1'b0;
        w_adv    = 1'b0;
        w_stop   = 1'b0;
        unique case (r_state)
            ST_BOOT: w_hold = 1'b0;
            ST_RUN: begin
                if (w_halt_hit) begin
                    w_stop   = 1'b1;
                    w_bubble = 1'b1;
                end else if (!bus.stall) begin
                    if (w_misalign) begin
                        w_stop   = 1'b1;
                        w_bubble = 1'b1;
                    end else begin
                        w_hold = 1'b0;
                        w_adv  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC;
            r_cnt       <= '0;
            r_halted    <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
            r_align_err <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_BOOT: begin
                    r_pc    <= w_pc4;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_stop) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (w_adv) begin
                        r_pc  <= bus.npc;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`ifdef PC_ALIGN_CHK_EN
                    if (w_align_trip) begin
                        r_align_err <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_hold   (w_hold),
        .i_bubble (w_bubble),
        .i_instr  (bus.instr_f),
        .i_pc     (r_pc),
        .o_instr  (w_instr_d),
        .o_pc     (w_pc_d),
        .o_valid  (w_valid_d)
    );

    assign bus.npc_sel   = w_sel;
    assign bus.pc_f      = r_pc;
    assign bus.pc4_f     = w_pc4;
    assign bus.instr_d   = w_instr_d;
    assign bus.pc_d      = w_pc_d;
    assign bus.pc8_d     = w_pc_d + 32'd8;
    assign bus.valid_d   = w_valid_d;
    assign bus.halted    = r_halted;
    assign bus.fetch_cnt = r_cnt;
`ifdef PC_ALIGN_CHK_EN
    assign bus.align_err = r_align_err;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: cycle model plus directed scenarios.
// Narrow fetch counter so its wrap is reachable.
module tb_pc_sequencer;

    localparam int          CW  = 4;
    localparam logic [31:0] RPC = 32'h0000_3000;
`ifdef PC_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] tgt     = 32'h0;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          cmp_on   = 1'b0;

    pc_sequencer_if #(.CNT_W(CW)) bus();

    pc_sequencer #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Instruction memory and next-PC mux around the DUT.
    assign bus.instr_f = imem(bus.pc_f);
    assign bus.npc     = (bus.npc_sel == 2'b00) ? bus.pc4_f : tgt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model of the fetch stage.
    logic [31:0]   m_pc;
    logic [31:0]   m_instr;
    logic [31:0]   m_pcd;
    logic          m_valid;
    logic          m_on;
    logic          m_stop;
    logic          m_aerr;
    logic [CW-1:0] m_cnt;

    function automatic logic [1:0] m_sel();
        if (!m_on || m_stop || !m_valid) return 2'b00;
        if (bus.j_d) return 2'b11;
        if (bus.jr_d) return 2'b10;
        if (bus.br_taken_d) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        logic [31:0] nx;
        if (!reset_n) begin
            m_pc = RPC; m_instr = 0; m_pcd = 0; m_valid = 0;
            m_on = 0; m_stop = 0; m_aerr = 0; m_cnt = 0;
        end else if (!m_on) begin
            m_instr = imem(m_pc); m_pcd = m_pc; m_valid = 1;
            m_cnt++; m_pc = m_pc + 32'd4; m_on = 1;
        end else if (!m_stop) begin
            nx = (m_sel() == 2'b00) ? m_pc + 32'd4 : tgt;
            if (bus.halt_req_d && m_valid) begin
                m_stop = 1; m_valid = 0; m_instr = 0;
            end else if (!bus.stall) begin
                if (ALIGN && (nx[1:0] != 2'b00)) begin
                    m_stop = 1; m_aerr = 1; m_valid = 0; m_instr = 0;
                end else begin
                    m_instr = imem(m_pc); m_pcd = m_pc; m_valid = 1;
                    m_cnt++; m_pc = nx;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("pc_f", bus.pc_f, m_pc);
            chk("pc4_f", bus.pc4_f, m_pc + 32'd4);
            chk("instr_d", bus.instr_d, m_instr);
            chk("pc_d", bus.pc_d, m_pcd);
            chk("pc8_d", bus.pc8_d, m_pcd + 32'd8);
            chk("valid_d", 32'(bus.valid_d), 32'(m_valid));
            chk("halted", 32'(bus.halted), 32'(m_stop));
            chk("fetch_cnt", 32'(bus.fetch_cnt), 32'(m_cnt));
            chk("npc_sel", 32'(bus.npc_sel), 32'(m_sel()));
`ifdef PC_ALIGN_CHK_EN
            chk("align_err", 32'(bus.align_err), 32'(m_aerr));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        bus.stall = 0; bus.br_taken_d = 0; bus.jr_d = 0;
        bus.j_d = 0; bus.halt_req_d = 0; tgt = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        clr();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        clr();
        repeat (2) @(posedge clk);
        cmp_on = 1;
        smp();
        chk("rst pc_f", bus.pc_f, 32'h3000);
        chk("rst valid_d", 32'(bus.valid_d), 32'd0);
        chk("rst halted", 32'(bus.halted), 32'd0);
        chk("rst cnt", 32'(bus.fetch_cnt), 32'd0);
        chk("rst instr_d", bus.instr_d, 32'd0);

        // Free-running fetch after reset.
        do_reset();
        smp(); chk("boot pc_f", bus.pc_f, 32'h3000);
        chk("boot valid_d", 32'(bus.valid_d), 32'd0);
        step(); smp(); chk("c1 pc_f", bus.pc_f, 32'h3004);
        chk("c1 valid_d", 32'(bus.valid_d), 32'd1);
        step(); smp(); chk("c2 pc_f", bus.pc_f, 32'h3008);
        step(); smp(); chk("c3 pc_f", bus.pc_f, 32'h300C);
        chk("c3 cnt", 32'(bus.fetch_cnt), 32'd3);

        // Taken branch with delay slot.
        do_reset();
        step(); step();
        bus.br_taken_d = 1; tgt = 32'h3040;
        smp(); chk("br sel", 32'(bus.npc_sel), 32'd1);
        chk("br pc_d0", bus.pc_d, 32'h3004);
        step(); bus.br_taken_d = 0;
        smp(); chk("br pc_f", bus.pc_f, 32'h3040);
        chk("br pc_d1", bus.pc_d, 32'h3008);
        step(); smp(); chk("br pc_d2", bus.pc_d, 32'h3040);
        chk("br instr_d", bus.instr_d, 32'h3040_CFBF);

        // j and jr together, target near the top of memory.
        do_reset();
        step();
        bus.j_d = 1; bus.jr_d = 1; tgt = 32'hFFFF_FFFC;
        smp(); chk("j sel", 32'(bus.npc_sel), 32'd3);
        step(); clr();
        smp(); chk("j pc_f", bus.pc_f, 32'hFFFF_FFFC);
        chk("wrap pc4_f", bus.pc4_f, 32'h0);
        step(); smp(); chk("wrap pc8_d", bus.pc8_d, 32'h4);
        chk("wrap pc_f", bus.pc_f, 32'h0);

        // Three-cycle stall on a jr.
        do_reset();
        step();
        bus.jr_d = 1; bus.stall = 1; tgt = 32'h3200;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("stl pc_f", bus.pc_f, 32'h3004);
            chk("stl instr_d", bus.instr_d, 32'h3000_CFFF);
            chk("stl cnt", 32'(bus.fetch_cnt), 32'd1);
            chk("stl sel", 32'(bus.npc_sel), 32'd2);
            if (k < 2) step();
        end
        step(); bus.stall = 0;
        smp(); chk("stl rel pc_f", bus.pc_f, 32'h3004);
        step(); bus.jr_d = 0;
        smp(); chk("jr pc_f", bus.pc_f, 32'h3200);
        chk("jr cnt", 32'(bus.fetch_cnt), 32'd2);

        // Halt under stall, frozen, then async reset.
        do_reset();
        step(); step();
        bus.halt_req_d = 1; bus.stall = 1;
        step(); clr();
        smp(); chk("hlt halted", 32'(bus.halted), 32'd1);
        chk("hlt valid_d", 32'(bus.valid_d), 32'd0);
        chk("hlt instr_d", bus.instr_d, 32'd0);
        for (int k = 0; k < 10; k++) begin
            step(); bus.br_taken_d = 1; bus.j_d = k[0]; tgt = 32'h3300;
            smp(); chk("hlt pc_f", bus.pc_f, 32'h3008);
            chk("hlt cnt", 32'(bus.fetch_cnt), 32'd2);
        end
        step(); reset_n = 0; clr();
        #1; chk("arst pc_f", bus.pc_f, 32'h3000);
        chk("arst halted", 32'(bus.halted), 32'd0);
        @(posedge clk); #2; reset_n = 1;

        // Reset discards an in-flight redirect.
        step(); bus.br_taken_d = 1; tgt = 32'h3400;
        #1; reset_n = 0;
        #1; chk("rdr pc_f", bus.pc_f, 32'h3000);
        clr();
        @(posedge clk); #2; reset_n = 1;
        step(); smp(); chk("rdr boot pc_f", bus.pc_f, 32'h3004);

        // Counter wrap.
        do_reset();
        repeat (20) step();
        smp(); chk("wrap cnt", 32'(bus.fetch_cnt), 32'd4);
        chk("wrap run pc_f", bus.pc_f, 32'h3050);

        // Misaligned jr target.
        do_reset();
        step();
        bus.jr_d = 1; tgt = 32'h3042;
        smp(); chk("mis sel", 32'(bus.npc_sel), 32'd2);
        step(); clr();
        smp();
`ifdef PC_ALIGN_CHK_EN
        chk("mis align_err", 32'(bus.align_err), 32'd1);
        chk("mis halted", 32'(bus.halted), 32'd1);
        chk("mis pc_f", bus.pc_f, 32'h3004);
        chk("mis valid_d", 32'(bus.valid_d), 32'd0);
`else
        chk("mis pc_f", bus.pc_f, 32'h3042);
        chk("mis halted", 32'(bus.halted), 32'd0);
`endif

        cmp_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage sequencer for the five-stage MIPS pipeline. It owns the PC register, the IF/ID pipeline register and the next-PC select code that drives the next-PC multiplexer. It applies hazard-unit stalls and ID-stage redirect requests (branch, `jr`, `j`/`jal`, with architectural delay slot, so no flush), and provides a halt state for end-of-program. It sits between instruction memory, the next-PC mux and the decode stage.

## Interface
Parameters:
- `RESET_PC`, `32'h0000_3000`, PC value loaded on reset.
- `CNT_W`, `32`, width of the fetch counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard stall; hold PC and IF/ID.
- `br_taken_d`  in  1  ID branch resolved as taken.
- `jr_d`  in  1  ID instruction is `jr`/`jalr`.
- `j_d`  in  1  ID instruction is `j`/`jal`.
- `halt_req_d`  in  1  ID instruction terminates the program.
- `npc`  in  32  selected next PC returned from the next-PC mux.
- `instr_f`  in  32  instruction-memory read data at `pc_f`.
- `npc_sel`  out  2  00 PC+4, 01 branch, 10 jr, 11 j/jal.
- `pc_f`  out  32  fetch address to instruction memory.
- `pc4_f`  out  32  `pc_f + 4`, to the mux PC4 input.
- `instr_d`  out  32  IF/ID instruction.
- `pc_d`  out  32  IF/ID PC.
- `pc8_d`  out  32  `pc_d + 8` (link value).
- `valid_d`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  sequencer is in HALT.
- `fetch_cnt`  out  CNT_W  number of instructions accepted into ID.

## Operation
- FSM states: BOOT, RUN, HALT.
- Reset values:
  - state = BOOT; `pc_f` = RESET_PC.
  - `instr_d`, `pc_d`, `fetch_cnt` = 0; `valid_d` = 0; `halted` = 0.
- BOOT: lasts one cycle. IF/ID loads `instr_f`/`pc_f` with `valid_d` = 1; PC loads `pc4_f`; go to RUN. `stall` is ignored in BOOT.
- `npc_sel` is combinational from the ID request inputs.
  - Priority: `j_d` > `jr_d` > `br_taken_d` > PC+4.
  - Outputs 00 when `valid_d` = 0 or state ≠ RUN.
- RUN, per cycle, in priority order:
  - `halt_req_d & valid_d`: go to HALT. IF/ID is loaded with a bubble (`instr_d` = 0, `valid_d` = 0). PC holds. This takes precedence over `stall`.
  - `stall`: PC, IF/ID and `fetch_cnt` hold. The redirect is re-evaluated next cycle from the held ID instruction.
  - Otherwise: PC ← `npc`; IF/ID ← {`instr_f`, `pc_f`}, `valid_d` = 1; `fetch_cnt` += 1 (wraps modulo 2^CNT_W).
- Delay slot: the instruction fetched in the same cycle as a redirect is kept. No squash.
- HALT: all registers frozen, `halted` = 1, `valid_d` = 0. Exit only through reset.
- `pc4_f` and `pc8_d` are unsigned 32-bit adds with wrap-around; no overflow flag.
- Reset asserted mid-operation returns to reset values immediately. An in-flight redirect is discarded.

## Timing
- Fetch-to-ID latency: 1 cycle.
- Redirect latency: the ID request in cycle N sets `pc_f` = target in cycle N+1. The delay-slot instruction enters ID in N+1; the target instruction enters ID in N+2.
- A stall of k cycles delays all of the above by exactly k cycles.
- `npc_sel` → mux → `npc` is a same-cycle combinational path. The PC register is the only sequential element on it.

## Configuration
- `PC_ALIGN_CHK_EN`:
  - Defined: when a RUN advance would load `npc` with `npc[1:0]` ≠ 0, the PC holds, state goes to HALT, and the extra output `align_err` (1 bit, reset 0) is set sticky. The IF/ID register loads a bubble.
  - Undefined: `npc` is loaded unchecked and the `align_err` port is absent.

## Structure
- Shared package `pipe_pkg` holds:
  - the `npc_sel` encodings: NPC_PC4, NPC_BR, NPC_JR, NPC_J;
  - the state enum: ST_BOOT, ST_RUN, ST_HALT;
  - RESET_PC;
  - the NOP word.
- One sub-module, `if_id_reg`: IF/ID register with hold and bubble-load controls. The FSM, PC register and counter stay in `pc_sequencer`.

## Test plan
- Reset release, no requests, 4 cycles → `pc_f` = 3000, 3004, 3008, 300C. `valid_d` rises one cycle after the BOOT cycle; `fetch_cnt` = 3.
- `br_taken_d` with `npc` = 0x3040 at `pc_f` = 0x3008 → `npc_sel` = 01. Next `pc_f` = 0x3040. `pc_d` sequence = 0x3004, 0x3008 (delay slot), 0x3040.
- `j_d` and `jr_d` asserted together → `npc_sel` = 11.
- `stall` held 3 cycles during `jr_d` → `pc_f`, `instr_d` and `fetch_cnt` are constant for 3 cycles, then redirect to `npc` on release.
- `halt_req_d` together with `stall` → HALT the next cycle, `halted` = 1, `valid_d` = 0. PC stays frozen for 10 cycles. Mid-run `reset_n` low → `pc_f` = 0x3000 immediately.
- `PC_ALIGN_CHK_EN` defined, `jr_d` with `npc` = 0x3042 → `align_err` = 1, HALT, `pc_f` unchanged.
